// File: rtl/gamma_sequencer.sv
// Gamma-cycle scheduler for the race-logic datapath: frames one gamma cycle with grst,
// drives edge-encoded operands a/b at their requested offsets and times the first rise of y.
module gamma_sequencer #(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned TW                = 5
) (
    input  logic          aclk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [TW-1:0] in_a_time,
    input  logic [TW-1:0] in_b_time,
    output logic          grst,
    output logic          a,
    output logic          b,
    input  logic          y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] out_time,
    output logic          busy
);
    localparam logic [TW-1:0] G_T    = TW'(GAMMA_CYCLE_WIDTH);
    localparam logic [TW-1:0] T_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRST, S_RUN, S_REPORT} state_e;

    state_e        state_q;
    logic [TW-1:0] t_q;
    logic [TW-1:0] t_d;
    logic [TW-1:0] a_time_q;
    logic [TW-1:0] b_time_q;
    logic [TW-1:0] cap_q;
    logic          captured_q;
    logic          grst_q;
    logic          a_q;
    logic          b_q;
    logic          out_valid_q;
    logic [TW-1:0] out_time_q;

    assign t_d = t_q + TW'(1);

    // in_ready follows rst directly so it is low throughout reset.
    assign in_ready  = rst & (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign grst      = grst_q;
    assign a         = a_q;
    assign b         = b_q;
    assign out_valid = out_valid_q;
    assign out_time  = out_time_q;

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            a_time_q    <= '0;
            b_time_q    <= '0;
            cap_q       <= '0;
            captured_q  <= 1'b0;
            grst_q      <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            out_valid_q <= 1'b0;
            out_time_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_time_q <= in_a_time;
                        b_time_q <= in_b_time;
                        grst_q   <= 1'b1;
                        state_q  <= S_GRST;
                    end
                end
                S_GRST: begin
                    grst_q     <= 1'b0;
                    t_q        <= '0;
                    cap_q      <= G_T;
                    captured_q <= 1'b0;
                    a_q        <= (a_time_q == '0);
                    b_q        <= (b_time_q == '0);
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    if (y && !captured_q) begin
                        cap_q      <= t_q;
                        captured_q <= 1'b1;
                    end
                    // A rise sampled on the final RUN edge bypasses cap_q into the result.
                    if (t_q == T_LAST) begin
                        a_q         <= 1'b0;
                        b_q         <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_time_q  <= (y && !captured_q) ? t_q : cap_q;
                        state_q     <= S_REPORT;
                    end else begin
                        t_q <= t_d;
                        a_q <= (t_d >= a_time_q);
                        b_q <= (t_d >= b_time_q);
                    end
                end
                S_REPORT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_time_q  <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/gamma_sequencer.md
# gamma_sequencer

Scheduler for the temporal (race-logic) datapath. It accepts one job at a time over a valid/ready handshake, frames one gamma cycle with a `grst` pulse, and drives the spike-time operands `a` and `b` as edge-encoded signals at their requested cycle offsets. It captures the arrival time of the datapath output `y` and returns it over a second valid/ready handshake. It sits between a host/stimulus source and a combinational temporal operator such as `min`.

## Interface

**Parameters**
- `GAMMA_CYCLE_WIDTH`, default 16: `aclk` cycles per gamma cycle (G). Must be a power of two, ≥ 4.
- `TW`, default 5: spike-time width, equal to $clog2(G)+1. A value ≥ G encodes "no spike" (infinity).

**Ports**
- `aclk`  in  1  operating clock.
- `rst`  in  1  reset, asynchronous assert, active-low. Logic 0 resets the block.
- `in_valid`  in  1  job request.
- `in_ready`  out  1  block can accept a job.
- `in_a_time`  in  TW  spike time for `a`.
- `in_b_time`  in  TW  spike time for `b`.
- `grst`  out  1  gamma-cycle reset to the datapath, active-high.
- `a`  out  1  edge-encoded operand A.
- `b`  out  1  edge-encoded operand B.
- `y`  in  1  datapath result, edge-encoded and rising-edge based.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_time`  out  TW  captured spike time of `y`.
- `busy`  out  1  a job is in progress (any state other than IDLE).

## Operation

**States: IDLE, GRST, RUN, REPORT.**

- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch `in_a_time` and `in_b_time`, then go to GRST.
- **GRST** (exactly 1 cycle)
  - `grst` = 1, `a` = `b` = 0.
  - Clear the counter `t` to 0 and set the capture register to G ("no spike"); clear the captured flag.
  - Go to RUN.
- **RUN** (exactly G cycles, `t` = 0 … G-1)
  - `a` is high in exactly those RUN cycles with `t` ≥ latched a_time; likewise `b`.
  - A latched time ≥ G means the signal stays low for the whole cycle.
  - `y` is sampled at each RUN edge. On the first sample with `y` = 1, capture `t` and set the captured flag. Later samples are ignored, so `y` dropping or glitching after capture has no effect.
  - When `t` = G-1, go to REPORT. The counter does not wrap within a job.
- **REPORT**
  - `out_valid` = 1, `out_time` = captured value (G if `y` never rose), `a` = `b` = `grst` = 0.
  - `out_valid` and `out_time` hold stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.

**Other rules**
- `in_ready` is 0 in every state except IDLE. `in_valid` outside IDLE is ignored and does not queue.
- `y` is not sampled in IDLE, GRST or REPORT. A `y` = 1 during GRST does not count.
- `a`, `b`, `grst`, `out_valid` and `out_time` are driven from registers or state decode only. There is no combinational path from `in_*` or `y` to any output.
- Arithmetic:
  - `t` is TW bits wide.
  - The comparison `t ≥ time` is unsigned at TW bits.
  - `out_time` ∈ [0, G].

## Timing

- **Reset:** while `rst` = 0 the state is IDLE and every output is 0, including `in_ready`. `in_ready` rises combinationally once `rst` = 1.
- **Reset mid-job:** asserting `rst` mid-job aborts immediately. No `out_valid` is produced, and `a`, `b`, `grst` drop asynchronously.
- **Cycle numbering:** edge 0 is the accept edge.
  - `grst` is high for the cycle between edges 0 and 1.
  - RUN `t` = k occupies the cycle between edges k+1 and k+2.
  - `a` rises at edge a_time+1.
  - `out_valid` rises at edge G+1 (17 for G = 16).
- **Capture latency:** with a zero-delay datapath, a `y` that follows `a` is sampled in the same cycle, so `out_time` equals the operand time exactly.
- **Throughput:** if `out_ready` is already 1, REPORT lasts 1 cycle. IDLE lasts at least 1 cycle, so the next accept is at edge G+3 at the earliest. That gives one job per G+3 cycles.

## Test plan

Unless stated otherwise, the bench models `y = a | b` (rising-edge min), uses G = 16, and holds `out_ready` = 1.

- **Back-to-back jobs, and reset:** a=2,b=4 → `out_time`=2; then a=6,b=1 → `out_time`=1. `busy` falls between the two jobs. Then pull `rst` low at RUN `t`=5 → all outputs 0 within the same cycle, no `out_valid`. Release → `in_ready`=1 and a new job completes normally.
- **a before b:** a=2, b=4 →
  - `grst` is a single 1-cycle pulse;
  - `a` is high for 14 cycles and `b` for 12;
  - `out_valid` rises at edge 17 with `out_time`=2.
- **b before a:** a=7, b=3 → `out_time`=3, and `a` is high for 9 cycles.
- **Simultaneous spikes:** a=5, b=5 → `a` and `b` rise on the same edge; `out_time`=5.
- **No spike:** a=16, b=20 → `a` and `b` never go high; `out_time`=16.
- **Early `y`, and backpressure:**
  - Force `y`=1 during GRST only, with a=b=16 → `out_time`=16.
  - Then run a=1,b=9 with `out_ready` held 0 for 5 cycles → `out_valid`=1 and `out_time`=1 stay stable, `in_ready`=0, and an `in_valid` pulse is ignored. The job is accepted on the edge after the output handshake.
